branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter XLEN, default 32, address/data width.
REQ-002 Parameter ENTRIES, default 16, table depth; power of two, IDX = log2(ENTRIES).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port lookup_pc  input  XLEN  fetch PC to predict.
REQ-006 Port pred_taken  output  1  predicted PCSrc for lookup_pc.
REQ-007 Port pred_target  output  XLEN  predicted next PC.
REQ-008 Port upd_valid  input  1  resolved branch present this cycle.
REQ-009 Port upd_pc  input  XLEN  PC of the resolved branch.
REQ-010 Port upd_taken  input  1  actual PCSrc from branch resolution.
REQ-011 Port upd_target  input  XLEN  actual branch target.
REQ-012 Port upd_pred_taken  input  1  prediction made for this branch at fetch.
REQ-013 Port upd_pred_target  input  XLEN  target predicted at fetch.
REQ-014 Port flush  input  1  invalidate the whole table.
REQ-015 Port mispredict  output  1  combinational, current update was mispredicted.
REQ-016 Port branch_cnt  output  32  resolved-branch count.
REQ-017 Port mispredict_cnt  output  32  mispredict count.

Function
REQ-018 Each entry SHALL hold: valid (1), tag (XLEN-IDX-2), target (XLEN), ctr (2-bit saturating).
REQ-019 Index SHALL be pc[IDX+1:2]; tag SHALL be pc[XLEN-1:IDX+2]; pc[1:0] ignored.
REQ-020 Lookup SHALL be combinational: hit = valid && tag match at lookup_pc index.
REQ-021 pred_taken SHALL be hit && ctr[1]; pred_target SHALL be entry target when pred_taken, else lookup_pc+4 (modulo 2^XLEN).
REQ-022 On upd_valid with hit at upd_pc: ctr SHALL increment if upd_taken, decrement otherwise, saturating at 2'b11 and 2'b00.
REQ-023 On upd_valid with hit and upd_taken: target SHALL be overwritten with upd_target.
REQ-024 On upd_valid with miss and upd_taken: entry SHALL be allocated (valid=1, tag, target=upd_target, ctr=2'b10), replacing any prior occupant.
REQ-025 On upd_valid with miss and !upd_taken: table SHALL be unchanged.
REQ-026 Table updates SHALL take effect at the next rising edge; same-cycle lookup of the updated index SHALL return pre-update state (no bypass).
REQ-027 mispredict SHALL be upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
REQ-028 branch_cnt SHALL increment on every upd_valid cycle; mispredict_cnt SHALL increment on every mispredict cycle; both saturate at 32'hFFFF_FFFF.
REQ-029 flush SHALL clear all valid bits at the next edge; ctr and target are left unchanged.
REQ-030 flush and upd_valid in the same cycle: flush SHALL win for table state; stat counters SHALL still update.
REQ-031 Stat counters SHALL NOT be cleared by flush.

Reset
REQ-032 rst_n low SHALL immediately clear all valid bits, set all ctr to 2'b01, targets to 0, branch_cnt and mispredict_cnt to 0.
REQ-033 During reset pred_taken SHALL be 0 and pred_target SHALL be lookup_pc+4.
REQ-034 Reset asserted mid-update SHALL discard that update.

Verification
REQ-035 After reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, counters 0.
REQ-036 Update pc=0x100 taken target=0x80, pred_taken=0 -> mispredict=1; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x80, mispredict_cnt=1, branch_cnt=1.
REQ-037 Two not-taken updates at 0x100 after allocation -> ctr 10->01->00; lookup -> pred_taken=0, pred_target=0x104; third not-taken keeps ctr=00.
REQ-038 Alias: allocate 0x100 (taken), then taken update at 0x140 (same index with ENTRIES=16) -> lookup 0x100 misses, 0x140 hits with its target.
REQ-039 flush with simultaneous taken update at 0x200 -> next cycle lookup 0x200 misses, branch_cnt still increments.
REQ-040 rst_n pulsed low asynchronously between edges after allocations -> all lookups miss immediately, counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookups are combinational; resolved branches update the table at the next edge.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  localparam int IDX    = $clog2(ENTRIES),
  localparam int TAGW   = XLEN - IDX - 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  input  logic            flush,
  output logic            mispredict,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispredict_cnt
);

  typedef struct packed {
    logic            valid;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } entry_t;

  entry_t          tbl_q [ENTRIES];
  entry_t          lk_e, up_e, upd_d;
  logic [IDX-1:0]  lk_idx, up_idx;
  logic            lk_hit, up_hit, upd_we;
  logic [31:0]     branch_cnt_q, mispredict_cnt_q;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign up_idx = upd_pc[IDX+1:2];
  assign lk_e   = tbl_q[lk_idx];
  assign up_e   = tbl_q[up_idx];
  assign lk_hit = lk_e.valid && (lk_e.tag == lookup_pc[XLEN-1:IDX+2]);
  assign up_hit = up_e.valid && (up_e.tag == upd_pc[XLEN-1:IDX+2]);

  assign pred_taken  = lk_hit && lk_e.ctr[1];
  assign pred_target = pred_taken ? lk_e.target : lookup_pc + XLEN'(4);

  assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                    (upd_taken && (upd_pred_target != upd_target)));

  always_comb begin
    upd_we = 1'b0;
    upd_d  = up_e;
    if (upd_valid) begin
      if (up_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          upd_d.target = upd_target;
          if (up_e.ctr != 2'b11) upd_d.ctr = up_e.ctr + 2'b01;
        end else if (up_e.ctr != 2'b00) begin
          upd_d.ctr = up_e.ctr - 2'b01;
        end
      end else if (upd_taken) begin
        upd_we       = 1'b1;
        upd_d.valid  = 1'b1;
        upd_d.tag    = upd_pc[XLEN-1:IDX+2];
        upd_d.target = upd_target;
        upd_d.ctr    = 2'b10;
      end
    end
  end

  // Flush takes priority over any same-cycle table write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid  <= 1'b0;
        tbl_q[i].tag    <= '0;
        tbl_q[i].target <= '0;
        tbl_q[i].ctr    <= 2'b01;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else if (upd_we) begin
      tbl_q[up_idx] <= upd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (upd_valid && (branch_cnt_q != '1))     branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict && (mispredict_cnt_q != '1)) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the predictor outputs.
module tb_branch_predictor;
  localparam int XLEN = 32;

  logic            gclk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            flush;
  logic            mispredict;
  logic [31:0]     branch_cnt;
  logic [31:0]     mispredict_cnt;

  typedef struct packed {
    logic [31:0]     id;
    logic            pt;
    logic [XLEN-1:0] ptgt;
    logic            mis;
    logic [31:0]     bc;
    logic [31:0]     mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(16)) dut (
    .clk(gclk), .rst_n(rst_n), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush(flush),
    .mispredict(mispredict), .branch_cnt(branch_cnt),
    .mispredict_cnt(mispredict_cnt)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL step%0d %s actual=%h required=%h", id, nm, act, req);
    end
  endtask

  always @(negedge gclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "pred_taken",     {31'd0, pred_taken}, {31'd0, e.pt});
      chk(e.id, "pred_target",    pred_target,         e.ptgt);
      chk(e.id, "mispredict",     {31'd0, mispredict}, {31'd0, e.mis});
      chk(e.id, "branch_cnt",     branch_cnt,          e.bc);
      chk(e.id, "mispredict_cnt", mispredict_cnt,      e.mc);
    end
  end

  // Inputs held for one full cycle starting just after a rising edge.
  task automatic step(input int id, input logic rst, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                      input logic fl, input logic ept, input logic [31:0] eptgt,
                      input logic emis, input logic [31:0] ebc, input logic [31:0] emc);
    exp_t e;
    rst_n = rst; lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt; flush = fl;
    e.id = id; e.pt = ept; e.ptgt = eptgt; e.mis = emis; e.bc = ebc; e.mc = emc;
    exp_q.push_back(e);
    @(posedge gclk); #1;
  endtask

  initial begin
    rst_n = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush = 1'b0;
    repeat (2) @(posedge gclk);
    #1;
    //   id rst lpc          uv upc     ut utgt    upt uptgt  fl  pt ptgt          mis bc mc
    step( 1, 0, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h104,      0, 0, 0);
    step( 2, 1, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h104,      0, 0, 0);
    step( 3, 1, 32'h100,      1, 32'h100, 1, 32'h80,  0, 32'h0,  0, 0, 32'h104,      1, 0, 0);
    step( 4, 1, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1, 32'h80,       0, 1, 1);
    step( 5, 1, 32'h100,      1, 32'h100, 0, 32'h0,   1, 32'h80, 0, 1, 32'h80,       1, 1, 1);
    step( 6, 1, 32'h100,      1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0, 32'h104,      0, 2, 2);
    step( 7, 1, 32'h100,      1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 0, 32'h104,      0, 3, 2);
    step( 8, 1, 32'h100,      1, 32'h100, 1, 32'h90,  0, 32'h0,  0, 0, 32'h104,      1, 4, 2);
    step( 9, 1, 32'h100,      1, 32'h100, 1, 32'h90,  0, 32'h0,  0, 0, 32'h104,      1, 5, 3);
    step(10, 1, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1, 32'h90,       0, 6, 4);
    step(11, 1, 32'h100,      1, 32'h100, 1, 32'h90,  1, 32'h94, 0, 1, 32'h90,       1, 6, 4);
    step(12, 1, 32'h100,      1, 32'h100, 1, 32'h90,  1, 32'h90, 0, 1, 32'h90,       0, 7, 5);
    step(13, 1, 32'h140,      1, 32'h140, 1, 32'h300, 0, 32'h0,  0, 0, 32'h144,      1, 8, 5);
    step(14, 1, 32'h100,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h104,      0, 9, 6);
    step(15, 1, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1, 32'h300,      0, 9, 6);
    step(16, 1, 32'h140,      1, 32'h180, 0, 32'h0,   0, 32'h0,  0, 1, 32'h300,      0, 9, 6);
    step(17, 1, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1, 32'h300,      0, 10, 6);
    step(18, 1, 32'h140,      1, 32'h200, 1, 32'h40,  0, 32'h0,  1, 1, 32'h300,      1, 10, 6);
    step(19, 1, 32'h200,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h204,      0, 11, 7);
    step(20, 1, 32'h140,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h144,      0, 11, 7);
    step(21, 1, 32'h104,      1, 32'h104, 1, 32'h10,  0, 32'h0,  0, 0, 32'h108,      1, 11, 7);
    step(22, 1, 32'h104,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 1, 32'h10,       0, 12, 8);
    step(23, 0, 32'h104,      1, 32'h104, 0, 32'h0,   1, 32'h10, 0, 0, 32'h108,      1, 0, 0);
    step(24, 1, 32'h104,      0, 32'h0,   0, 32'h0,   0, 32'h0,  0, 0, 32'h108,      0, 0, 0);
    step(25, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 32'h0,   0, 32'h0,  0, 0, 32'h0,        0, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge gclk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
